serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and sum width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 in_valid  input  1  SHALL mean operands a, b, cin are presented.
REQ-005 in_ready  output  1  SHALL mean the block can accept operands this cycle.
REQ-006 a  input  WIDTH  SHALL be addend A.
REQ-007 b  input  WIDTH  SHALL be addend B.
REQ-008 cin  input  1  SHALL be the carry-in.
REQ-009 out_valid  output  1  SHALL mean sum and cout hold a completed result.
REQ-010 out_ready  input  1  SHALL mean the consumer takes the result this cycle.
REQ-011 sum  output  WIDTH  SHALL be the result A+B+cin modulo 2^WIDTH.
REQ-012 cout  output  1  SHALL be the carry out of bit WIDTH-1.
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-014 The block SHALL be an FSM with states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE->RUN on in_valid&&in_ready; that edge SHALL capture a, b into shift registers, cin into the carry register, and clear the bit counter to 0.
REQ-017 Each RUN edge SHALL add one bit, LSB first, through one 1-bit full-adder cell (operand LSBs plus carry register), shift the sum bit into sum from the MSB end, update the carry register with the cell carry, and increment the counter.
REQ-018 RUN->DONE SHALL occur on the edge processing bit WIDTH-1; out_valid SHALL therefore rise exactly WIDTH edges after the accepting edge.
REQ-019 In DONE, sum and cout SHALL stay stable until out_valid&&out_ready; that edge SHALL return to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE; captured operands SHALL be unaffected by input changes during RUN/DONE.
REQ-021 No new operand SHALL be accepted on the DONE->IDLE edge; minimum initiation interval SHALL be WIDTH+2 cycles.
REQ-022 Bit counter width SHALL be clog2(WIDTH); counter SHALL never wrap within one operation.

Reset
REQ-023 rst_n low at a clock edge SHALL force IDLE, counter 0, carry 0, sum 0, cout 0, out_valid 0, busy 0, in_ready 1 on the following cycle, from any state.
REQ-024 Reset mid-RUN or mid-DONE SHALL discard the operation with no partial result ever presented.

Configuration
REQ-025 With macro SERIAL_ADD_OVF_EN defined, output ovf (1 bit) SHALL be added, equal to carry into bit WIDTH-1 XOR cout, valid with out_valid, reset to 0.
REQ-026 Without SERIAL_ADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-028 The 1-bit full adder SHALL be a separate sub-module, fa_bit_cell (sum = a^b^cin, cout = majority), instantiated once.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x3C, cin=0 -> out_valid 8 edges after accept; sum=0x96, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 out_ready held 0 for 5 cycles in DONE -> sum/cout/out_valid stable; in_ready=0 and in_valid pulses ignored throughout.
REQ-032 rst_n low at RUN bit 3 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; following op a=0x01, b=0x02 -> sum=0x03.
REQ-033 SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x10, b=0x20 -> ovf=0.
REQ-034 Back-to-back in_valid held high -> accepts spaced exactly WIDTH+2 cycles when out_ready=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand / sum width in bits
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// fa_bit_cell
// Single-bit full adder used by the serial datapath.
//   a, b, cin : operand bits and carry in
//   s         : sum bit
//   cout      : carry out (majority of the three inputs)
module fa_bit_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder: accepts A, B, cin with a valid/ready handshake, adds one
// bit per clock LSB first through a single full-adder cell, then holds the
// result until the consumer takes it.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high whenever the FSM is not IDLE
//   ovf                 : signed overflow, present only with SERIAL_ADD_OVF_EN
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding one bit per edge, counter = bit index being processed
// DONE  | result held on sum/cout, out_valid high
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   assign last_bit = (cnt == LAST_BIT);

   fa_bit_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               carry  <= fa_c;
               // Counter stops at the last index rather than wrapping.
               if (last_bit) state <= DONE;
               else          cnt   <= cnt + 1'b1;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   // Partial sums never leave the block: outputs are zero outside DONE.
   assign sum       = out_valid ? sum_sh : '0;
   assign cout      = out_valid & carry;

`ifdef SERIAL_ADD_OVF_EN
   // Carry entering the MSB cell, captured while that bit is processed.
   logic c_msb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_msb <= 1'b0;
      end else if (state == RUN && last_bit) begin
         c_msb <= carry;
      end
   end

   assign ovf = out_valid & (c_msb ^ carry);
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Directed bench for serial_add_ctrl at WIDTH=8. Build with SERIAL_ADD_OVF_EN
// defined to also exercise the ovf output.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Full transaction: accept, measure latency, check result, consume it.
   task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] e_sum, input logic e_cout);
      int n;
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      a = va; b = vb; cin = vc; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = ~va; b = ~vb; cin = ~vc;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'd8);
      chk({tag, " sum"}, 32'(sum), 32'(e_sum));
      chk({tag, " cout"}, 32'(cout), 32'(e_cout));
`ifdef SERIAL_ADD_OVF_EN
      // Signed overflow: operands share a sign the result does not.
      chk({tag, " ovf"}, 32'(ovf), 32'((va[7] == vb[7]) && (e_sum[7] != va[7])));
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " idle after"}, 32'({in_ready, out_valid, busy}), 32'b100);
   endtask

   initial begin
      int n;
      int cyc;
      int acc[$];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("reset ready/valid/busy", 32'({in_ready, out_valid, busy}), 32'b100);
      chk("reset sum", 32'(sum), 32'h0);
      chk("reset cout", 32'(cout), 32'h0);

      do_op("5a+3c",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
      do_op("ff+01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      do_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      do_op("7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      do_op("80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      do_op("10+20",   8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

      // Stall in DONE with in_valid pulses that must be ignored.
      a = 8'h5A; b = 8'h3C; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         in_valid = n[0];
         a = 8'hFF; b = 8'hFF; cin = 1'b1;
         chk("run in_ready low", 32'(in_ready), 32'd0);
         step();
         n++;
      end
      chk("stall latency", 32'(n), 32'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         step();
         chk("stall out_valid", 32'(out_valid), 32'd1);
         chk("stall sum", 32'(sum), 32'h96);
         chk("stall cout", 32'(cout), 32'd0);
         chk("stall in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("stall release idle", 32'({in_ready, out_valid, busy}), 32'b100);

      // Reset asserted on the edge that processes bit 3.
      a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      chk("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrun reset state", 32'({in_ready, out_valid, busy}), 32'b100);
      chk("midrun reset sum", 32'(sum), 32'h0);
      chk("midrun reset cout", 32'(cout), 32'h0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("no stale result", 32'(out_valid), 32'd0);
      end
      do_op("01+02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

      // Back-to-back: in_valid and out_ready held high.
      a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      cyc = 0;
      while (cyc < 35) begin
         if (in_ready) acc.push_back(cyc);
         if (out_valid) chk("b2b sum", 32'({cout, sum}), 32'h047);
         step();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b accept count", 32'(acc.size()), 32'd4);
      for (int i = 1; i < acc.size(); i++)
         chk("b2b spacing", 32'(acc[i] - acc[i-1]), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
